// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the FIR coefficient/sequencing controller.
// Holds the FSM state encoding, the schedule constants and the mapping from
// coefficient index k (1..12) to {bank, address} in the split SRAM banks.
package fir_ctrl_pkg;

    localparam int ADDR_W = 4;

    // Schedule constants, typed to the widths of the counters they are compared with.
    localparam logic [3:0] P_NUM_COEFF = 4'd12;  // coefficients per update
    localparam logic [4:0] P_ACC_CYC   = 5'd7;   // read/accumulate cycles per sample
    localparam logic [4:0] P_WIN_CYC   = 5'd20;  // cycles per sample window
    localparam logic [4:0] P_NEG_TAPS  = 5'd5;   // negative-bank taps read during ACC

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_ACC  = 3'd3;
    localparam logic [2:0] ST_SUM  = 3'd4;

    typedef struct packed {
        logic              neg;   // 1: negative bank, 0: positive bank
        logic [ADDR_W-1:0] addr;
    } bank_addr_t;

    // k 1..10 alternate pos/neg (odd -> pos (k+1)/2, even -> neg k/2);
    // the two extra taps 11 and 12 live at pos 6 and pos 7.
    function automatic bank_addr_t coeff_map(input logic [5:0] k);
        bank_addr_t r;
        r.neg  = 1'b0;
        r.addr = '0;
        if (k >= 6'd1 && k <= 6'd10) begin
            r.neg  = ~k[0];
            r.addr = k[4:1] + {3'b000, k[0]};
        end else if (k == 6'd11) begin
            r.addr = 4'd6;
        end else if (k == 6'd12) begin
            r.addr = 4'd7;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_coeff_addr_map.sv
// Combinational coefficient index -> SRAM bank/address decoder.
// Ports:
//   k     in  6  coefficient index (1..12; other values decode to pos 0)
//   neg   out 1  1 when the coefficient lives in the negative bank
//   addr  out 4  address within the selected bank
module fir_coeff_addr_map
    import fir_ctrl_pkg::*;
(
    input  logic [5:0]        k,
    output logic              neg,
    output logic [ADDR_W-1:0] addr
);

    bank_addr_t map;

    always_comb begin
        map  = coeff_map(k);
        neg  = map.neg;
        addr = map.addr;
    end

endmodule

// File: rtl/fir_coeff_ctrl.sv
// Sequencing controller for the reconfigurable FIR datapath.
// Loads a 12-coefficient set from a host (valid/ready) into the positive and
// negative coefficient SRAM banks, then runs the 20-cycle read/accumulate/sum
// schedule on every sample strobe. Host updates requested mid-window are held
// in a pending bit and serviced only once the window has completed.
// Ports:
//   iClk_12M, iRst            clock, synchronous active-high reset
//   iEnSample_600k            one-cycle sample strobe
//   iUpdReq                   one-cycle coefficient update request
//   iCfgValid/oCfgReady/iCfgData  host coefficient beat handshake
//   oCoeffiUpdateFlag         high while loading
//   oCsnRam/oWrnRam           SRAM chip select / write enable (active low)
//   oAddrRam_pos/_neg         bank addresses
//   oWrDtRam, oNumOfCoeff     write data and index of coefficient written
//   oCoeffValid               full coefficient set resident
//   oSumStrobe/oLoadDone/oOverrun  single-cycle event pulses
// All outputs are registered.
module fir_coeff_ctrl
    import fir_ctrl_pkg::*;
(
    input  logic              iClk_12M,
    input  logic              iRst,
    input  logic              iEnSample_600k,
    input  logic              iUpdReq,
    input  logic              iCfgValid,
    output logic              oCfgReady,
    input  logic [15:0]       iCfgData,
    output logic              oCoeffiUpdateFlag,
    output logic              oCsnRam,
    output logic              oWrnRam,
    output logic [ADDR_W-1:0] oAddrRam_pos,
    output logic [ADDR_W-1:0] oAddrRam_neg,
    output logic [15:0]       oWrDtRam,
    output logic [5:0]        oNumOfCoeff,
    output logic              oCoeffValid,
    output logic              oSumStrobe,
    output logic              oLoadDone,
    output logic              oOverrun
);

    logic [2:0] state_reg, state_next;
    logic [3:0] beat_cnt_reg, beat_cnt_next;
    logic [4:0] win_cnt_reg, win_cnt_next;   // 1..20 position within a window
    logic       pending_reg, pending_next;

    logic              cfg_ready_next, upd_flag_next, csn_next, wrn_next;
    logic [ADDR_W-1:0] pos_next, neg_next;
    logic [15:0]       wr_dt_next;
    logic [5:0]        num_next;
    logic              coeff_valid_next, sum_strobe_next, load_done_next, overrun_next;

    logic              accept;
    logic              win_last;
    logic [5:0]        beat_k;
    logic              map_neg;
    logic [ADDR_W-1:0] map_addr;

    assign accept   = (state_reg == ST_LOAD) && iCfgValid && oCfgReady;
    assign win_last = (state_reg == ST_SUM) && (win_cnt_reg == P_WIN_CYC);
    assign beat_k   = {2'b00, beat_cnt_reg} + 6'd1;

    fir_coeff_addr_map u_addr_map (
        .k    (beat_k),
        .neg  (map_neg),
        .addr (map_addr)
    );

    // Next-state, counters and event pulses
    always_comb begin
        state_next     = state_reg;
        beat_cnt_next  = beat_cnt_reg;
        win_cnt_next   = win_cnt_reg;
        pending_next   = pending_reg;
        overrun_next   = 1'b0;
        load_done_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // No coefficients resident: strobes are silently ignored.
                if (iUpdReq) begin
                    state_next    = ST_LOAD;
                    beat_cnt_next = '0;
                end
            end
            ST_LOAD: begin
                if (accept)
                    beat_cnt_next = beat_cnt_reg + 4'd1;
                if (iEnSample_600k)
                    overrun_next = 1'b1;
                // beat_cnt_reg reaches 12 in the cycle carrying the 12th write
                if (beat_cnt_reg == P_NUM_COEFF) begin
                    state_next     = ST_WAIT;
                    load_done_next = 1'b1;
                end
            end
            ST_WAIT: begin
                if (iEnSample_600k) begin
                    state_next   = ST_ACC;
                    win_cnt_next = 5'd1;
                    if (iUpdReq)
                        pending_next = 1'b1;
                end else if (iUpdReq) begin
                    state_next    = ST_LOAD;
                    beat_cnt_next = '0;
                end
            end
            ST_ACC, ST_SUM: begin
                if (iUpdReq)
                    pending_next = 1'b1;
                if (win_last) begin
                    // The final SUM cycle is the only point a new strobe or an update may start.
                    if (iEnSample_600k) begin
                        state_next   = ST_ACC;
                        win_cnt_next = 5'd1;
                    end else if (pending_reg || iUpdReq) begin
                        state_next    = ST_LOAD;
                        beat_cnt_next = '0;
                        pending_next  = 1'b0;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end else begin
                    if (iEnSample_600k)
                        overrun_next = 1'b1;
                    win_cnt_next = win_cnt_reg + 5'd1;
                    state_next   = (win_cnt_next > P_ACC_CYC) ? ST_SUM : ST_ACC;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output is registered
    always_comb begin
        cfg_ready_next   = 1'b0;
        upd_flag_next    = 1'b0;
        csn_next         = 1'b1;
        wrn_next         = 1'b1;
        pos_next         = '0;
        neg_next         = '0;
        wr_dt_next       = oWrDtRam;
        num_next         = oNumOfCoeff;
        coeff_valid_next = 1'b0;
        sum_strobe_next  = 1'b0;
        case (state_next)
            ST_LOAD: begin
                upd_flag_next  = 1'b1;
                cfg_ready_next = (beat_cnt_next != P_NUM_COEFF);
                if (accept) begin
                    csn_next   = 1'b0;
                    wrn_next   = 1'b0;
                    pos_next   = map_neg ? '0 : map_addr;
                    neg_next   = map_neg ? map_addr : '0;
                    wr_dt_next = iCfgData;
                    num_next   = beat_k;
                end
            end
            ST_WAIT: coeff_valid_next = 1'b1;
            ST_ACC: begin
                coeff_valid_next = 1'b1;
                csn_next         = 1'b0;
                pos_next         = win_cnt_next[ADDR_W-1:0];
                neg_next         = (win_cnt_next <= P_NEG_TAPS) ? win_cnt_next[ADDR_W-1:0] : '0;
            end
            ST_SUM: begin
                coeff_valid_next = 1'b1;
                sum_strobe_next  = (win_cnt_next == P_WIN_CYC);
            end
            default: ;
        endcase
    end

    always_ff @(posedge iClk_12M) begin
        if (iRst) begin
            state_reg         <= ST_IDLE;
            beat_cnt_reg      <= '0;
            win_cnt_reg       <= '0;
            pending_reg       <= 1'b0;
            oCfgReady         <= 1'b0;
            oCoeffiUpdateFlag <= 1'b0;
            oCsnRam           <= 1'b1;
            oWrnRam           <= 1'b1;
            oAddrRam_pos      <= '0;
            oAddrRam_neg      <= '0;
            oWrDtRam          <= '0;
            oNumOfCoeff       <= '0;
            oCoeffValid       <= 1'b0;
            oSumStrobe        <= 1'b0;
            oLoadDone         <= 1'b0;
            oOverrun          <= 1'b0;
        end else begin
            state_reg         <= state_next;
            beat_cnt_reg      <= beat_cnt_next;
            win_cnt_reg       <= win_cnt_next;
            pending_reg       <= pending_next;
            oCfgReady         <= cfg_ready_next;
            oCoeffiUpdateFlag <= upd_flag_next;
            oCsnRam           <= csn_next;
            oWrnRam           <= wrn_next;
            oAddrRam_pos      <= pos_next;
            oAddrRam_neg      <= neg_next;
            oWrDtRam          <= wr_dt_next;
            oNumOfCoeff       <= num_next;
            oCoeffValid       <= coeff_valid_next;
            oSumStrobe        <= sum_strobe_next;
            oLoadDone         <= load_done_next;
            oOverrun          <= overrun_next;
        end
    end

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Directed bench for fir_coeff_ctrl: table-driven coefficient load checks plus
// hand-written window, overrun, pending-update and reset sequences.
module tb_fir_coeff_ctrl;

    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic        strobe = 1'b0;
    logic        upd = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [15:0] cfg_data = '0;
    logic        cfg_ready, upd_flag, csn, wrn, coeff_valid, sum_strobe, load_done, overrun;
    logic [3:0]  addr_pos, addr_neg;
    logic [15:0] wr_dt;
    logic [5:0]  num_coeff;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  pos;
        logic [3:0]  neg;
    } coeff_vec_t;

    coeff_vec_t tbl [12];

    always #5 clk = ~clk;

    fir_coeff_ctrl dut (
        .iClk_12M          (clk),
        .iRst              (srst),
        .iEnSample_600k    (strobe),
        .iUpdReq           (upd),
        .iCfgValid         (cfg_valid),
        .oCfgReady         (cfg_ready),
        .iCfgData          (cfg_data),
        .oCoeffiUpdateFlag (upd_flag),
        .oCsnRam           (csn),
        .oWrnRam           (wrn),
        .oAddrRam_pos      (addr_pos),
        .oAddrRam_neg      (addr_neg),
        .oWrDtRam          (wr_dt),
        .oNumOfCoeff       (num_coeff),
        .oCoeffValid       (coeff_valid),
        .oSumStrobe        (sum_strobe),
        .oLoadDone         (load_done),
        .oOverrun          (overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
            $display("ok   %s: %0h", name, act);
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // All outputs at reset values, packed in a fixed order
    task automatic check_reset_state(input string name);
        check(name, {csn, wrn, addr_pos, addr_neg, wr_dt, num_coeff, cfg_ready, upd_flag,
                     coeff_valid, sum_strobe, load_done, overrun},
              {1'b1, 1'b1, 4'd0, 4'd0, 16'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    // Precondition: current cycle is the first LOAD cycle. ovr_beat >= 0 pulses
    // the strobe in the cycle that accepts that beat.
    task automatic do_load(input int ovr_beat);
        check("load entry {flag,ready,valid}", {upd_flag, cfg_ready, coeff_valid}, 3'b110);
        for (int i = 0; i < 12; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = tbl[i].data;
            strobe    = (i == ovr_beat);
            tick();
            strobe = 1'b0;
            check($sformatf("write k=%0d {csn,wrn,pos,neg,data,num,ovr}", i + 1),
                  {csn, wrn, addr_pos, addr_neg, wr_dt, num_coeff, overrun},
                  {1'b0, 1'b0, tbl[i].pos, tbl[i].neg, tbl[i].data, 6'(i + 1), 1'(i == ovr_beat)});
        end
        // Valid stays high: the 12th write cycle must no longer be accepting.
        check("ready low during write 12", {cfg_ready, upd_flag}, 2'b01);
        tick();
        check("load done {done,valid,csn,ready,flag}",
              {load_done, coeff_valid, csn, cfg_ready, upd_flag}, 5'b11100);
        cfg_valid = 1'b0;
        tick();
        check("load done one cycle wide", {load_done, coeff_valid}, 2'b01);
    endtask

    // Precondition: strobe already driven for the current cycle t.
    task automatic window(input int ovr_at, input int upd_at, input bit b2b);
        logic [3:0] ep, en;
        for (int c = 1; c <= 20; c++) begin
            tick();
            strobe = 1'b0;
            upd    = 1'b0;
            ep = (c <= 7) ? 4'(c) : 4'd0;
            en = (c <= 5) ? 4'(c) : 4'd0;
            check($sformatf("win c=%0d {csn,wrn,pos,neg,sum,ovr,valid}", c),
                  {csn, wrn, addr_pos, addr_neg, sum_strobe, overrun, coeff_valid},
                  {1'(c > 7), 1'b1, ep, en, 1'(c == 20), 1'(c == ovr_at + 1), 1'b1});
            if (c == ovr_at) strobe = 1'b1;
            if (c == upd_at) upd = 1'b1;
            if (c == 20 && b2b) strobe = 1'b1;
        end
    endtask

    initial begin
        int bad;
        tbl[0]  = '{16'h0003, 4'd1, 4'd0};
        tbl[1]  = '{16'h0006, 4'd0, 4'd1};
        tbl[2]  = '{16'h0007, 4'd2, 4'd0};
        tbl[3]  = '{16'h000B, 4'd0, 4'd2};
        tbl[4]  = '{16'h000D, 4'd3, 4'd0};
        tbl[5]  = '{16'h0013, 4'd0, 4'd3};
        tbl[6]  = '{16'h0018, 4'd4, 4'd0};
        tbl[7]  = '{16'h0025, 4'd0, 4'd4};
        tbl[8]  = '{16'h0030, 4'd5, 4'd0};
        tbl[9]  = '{16'h0066, 4'd0, 4'd5};
        tbl[10] = '{16'h00CE, 4'd6, 4'd0};
        tbl[11] = '{16'h01F4, 4'd7, 4'd0};

        repeat (3) tick();
        check_reset_state("reset state");
        srst = 1'b0;

        // Strobe in IDLE is ignored
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        tick();
        check("idle strobe ignored {csn,ovr,valid}", {csn, overrun, coeff_valid}, 3'b100);

        // Initial load
        upd = 1'b1;
        tick();
        upd = 1'b0;
        do_load(-1);

        // Two back-to-back windows, then one isolated window with an overrun
        repeat (2) tick();
        strobe = 1'b1;
        window(-1, -1, 1'b1);
        window(-1, -1, 1'b0);
        tick();
        check("wait after windows {csn,sum,flag,valid}", {csn, sum_strobe, upd_flag, coeff_valid}, 4'b1001);
        tick();
        strobe = 1'b1;
        window(10, -1, 1'b0);
        tick();
        check("overrun window returns to wait {csn,flag,ovr}", {csn, upd_flag, overrun}, 3'b100);

        // Update request during ACC: serviced after the window, strobe during LOAD overruns
        tick();
        strobe = 1'b1;
        window(-1, 3, 1'b0);
        tick();
        check("pending update enters load {sum,flag,valid}", {sum_strobe, upd_flag, coeff_valid}, 3'b010);
        do_load(4);

        // Same-cycle strobe and request in WAIT: window first, then LOAD
        tick();
        strobe = 1'b1;
        upd    = 1'b1;
        window(-1, -1, 1'b0);
        tick();
        check("strobe+req: load after window {flag,ready,valid}", {upd_flag, cfg_ready, coeff_valid}, 3'b110);
        do_load(-1);

        // Reset during LOAD after 5 beats
        upd = 1'b1;
        tick();
        upd = 1'b0;
        cfg_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cfg_data = tbl[i].data;
            tick();
        end
        check("partial load 5th write {csn,num}", {csn, num_coeff}, {1'b0, 6'd5});
        cfg_valid = 1'b0;
        srst = 1'b1;
        tick();
        check_reset_state("reset mid-load");
        srst = 1'b0;
        bad = 0;
        for (int c = 0; c < 25; c++) begin
            strobe = (c == 0 || c == 21);
            tick();
            if (csn !== 1'b1 || overrun !== 1'b0 || coeff_valid !== 1'b0 || sum_strobe !== 1'b0) bad++;
        end
        strobe = 1'b0;
        check("strobes ignored after reset (bad cycles)", 64'(bad), 64'd0);

        // Full reload then a normal window
        upd = 1'b1;
        tick();
        upd = 1'b0;
        do_load(-1);
        strobe = 1'b1;
        window(-1, -1, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fir_coeff_ctrl.md
# fir_coeff_ctrl

Sequencing controller for the reconfigurable FIR datapath (ReConf_FirFilter). It accepts a 12-coefficient update stream from a host over a valid/ready handshake and writes it into the filter's positive and negative coefficient SRAM banks. Once coefficients are loaded, it runs the per-sample read/accumulate/sum schedule on every 600 kHz strobe. It also arbitrates between host updates and live sample processing, so that a sample window is never corrupted.

## Interface
- P_NUM_COEFF, 12: coefficients per update (fixed mapping below; other values unsupported)
- P_ACC_CYC, 7: read/accumulate cycles per sample
- P_WIN_CYC, 20: cycles per sample window (12 MHz / 600 kHz)

- iClk_12M  in  1  system clock, 12 MHz
- iRst  in  1  synchronous, active-high reset
- iEnSample_600k  in  1  one-cycle sample strobe
- iUpdReq  in  1  one-cycle coefficient-update request
- iCfgValid  in  1  host coefficient beat valid
- oCfgReady  out  1  controller accepts a beat
- iCfgData  in  16  signed coefficient magnitude (beat k = coefficient k, k = 1..12)
- oCoeffiUpdateFlag  out  1  high throughout LOAD
- oCsnRam  out  1  SRAM chip select, active low
- oWrnRam  out  1  SRAM write enable, active low
- oAddrRam_pos  out  4  positive-bank address
- oAddrRam_neg  out  4  negative-bank address
- oWrDtRam  out  16  SRAM write data
- oNumOfCoeff  out  6  coefficient index being written
- oCoeffValid  out  1  a full coefficient set is resident
- oSumStrobe  out  1  pulse on the final SUM cycle (filter latches output)
- oLoadDone  out  1  pulse after the 12th write
- oOverrun  out  1  pulse when a strobe is dropped

## Operation
- States: IDLE, LOAD, WAIT, ACC, SUM. All outputs are registered.
- Reset values:
  - state IDLE
  - oCsnRam = 1, oWrnRam = 1
  - addresses 0, oWrDtRam 0, oNumOfCoeff 0
  - all flags and pulses 0
  - beat counter 0, pending-update bit 0
- Coefficient mapping, beat k:
  - k ≤ 10, k odd → pos addr (k+1)/2
  - k ≤ 10, k even → neg addr k/2
  - k = 11 → pos 6
  - k = 12 → pos 7
  - The unused bank's address is driven to 0.
- IDLE:
  - iUpdReq → LOAD.
  - Strobes are ignored; no overrun is flagged because no coefficients are resident.
- LOAD:
  - oCoeffiUpdateFlag = 1, oCfgReady = 1, oCoeffValid = 0.
  - Each accepted beat (iCfgValid & oCfgReady) produces, on the next cycle, one write cycle: oCsnRam = 0, oWrnRam = 0, mapped address, oWrDtRam = data, oNumOfCoeff = k.
  - Cycles with no accepted beat drive oCsnRam = 1, oWrnRam = 1.
  - After the 12th write cycle: oCfgReady drops, oLoadDone pulses, oCoeffValid = 1, next state WAIT.
  - Strobes during LOAD → oOverrun pulse. iUpdReq during LOAD is ignored.
- WAIT:
  - iEnSample_600k → ACC.
  - Otherwise iUpdReq → LOAD.
  - Strobe and request in the same cycle: the strobe wins and the pending bit is set.
- ACC, cycle c = 1..7:
  - oCsnRam = 0, oWrnRam = 1.
  - oAddrRam_pos = c; oAddrRam_neg = c for c ≤ 5, else 0.
- SUM, 13 cycles:
  - oCsnRam = 1, addresses 0.
  - Last cycle: oSumStrobe = 1.
  - From the last cycle:
    - strobe present → ACC (back-to-back window)
    - else pending bit set → LOAD (pending cleared)
    - else → WAIT
- iUpdReq during ACC/SUM sets the pending bit; the update is serviced after the window completes.
- A strobe during ACC or a non-final SUM cycle → oOverrun pulse; the strobe is dropped.
- iRst asserted mid-operation (any state): return to IDLE next cycle, oCoeffValid = 0, and a full reload is required.

## Timing
- Strobe sampled at cycle t:
  - ACC on t+1..t+7
  - SUM on t+8..t+20
  - oSumStrobe at t+20
  - The next strobe at t+20 starts ACC at t+21, giving a zero-gap 20-cycle period.
- Beat accepted at cycle t → SRAM write at t+1.
- Minimum load time: 13 cycles from the first accept to oLoadDone, with continuous valid.
- oLoadDone, oSumStrobe and oOverrun are each exactly one cycle wide.

## Structure
- Shared package fir_ctrl_pkg holds:
  - state encoding
  - P_NUM_COEFF, P_ACC_CYC, P_WIN_CYC
  - the 4-bit address width
  - the index-to-bank/address mapping function
- One natural sub-module: fir_coeff_addr_map (combinational k → {bank, addr}), shared with the verification model.
- The window counter, beat counter and pending bit stay in the top level.

## Test plan
- Load with continuous valid, data 0x0003, 0x0006, 0x0007, 0x000B, 0x000D, 0x0013, 0x0018, 0x0025, 0x0030, 0x0066, 0x00CE, 0x01F4:
  - 12 write cycles: pos addrs 1..7 and neg addrs 1..5 per the mapping, data matching.
  - oLoadDone 13 cycles after the first accept; oCoeffValid = 1.
- Strobes every 20 cycles after load:
  - each window: pos 1..7 and neg 1..5,0,0, oCsnRam low for exactly 7 cycles.
  - oSumStrobe 20 cycles after its strobe; no oOverrun.
- Strobe 10 cycles into a window → oOverrun pulse; the schedule is unchanged.
- iUpdReq during ACC → the window completes, LOAD is entered from the last SUM cycle, and oCoeffValid drops.
- Same-cycle strobe and iUpdReq in WAIT → ACC first, then LOAD after oSumStrobe.
- iRst during LOAD after 5 beats → IDLE with all outputs at reset values; strobes are ignored until a full reload.
